// File: rtl/synth_spi_master.sv
// Byte-framed SPI mode-0 master: sends address, optional data bytes and an optional
// kick byte, with slave select raised and a fixed idle gap after every byte.
module synth_spi_master #(
  parameter int HALF_DIV = 2600,
  parameter int GAP_BITS = 4
) (
  input  logic        i_clk50mhz,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_addr,
  input  logic [15:0] i_data,
  input  logic [1:0]  i_nbytes,
  input  logic        i_kick,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_spi_clk,
  output logic        o_spi_mosi,
  output logic        o_spi_ss,
  input  logic        i_spi_miso,
  output logic [7:0]  o_miso_byte
);

  localparam int GAP_LEN = GAP_BITS * 2 * HALF_DIV;
  localparam int DW = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
  localparam int GW = $clog2(GAP_LEN);
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]  half_q, half_d;
  logic [2:0]  bytes_left_q, bytes_left_d;
  logic [23:0] frame_q, frame_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  miso_byte_q, miso_byte_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        ss_q, ss_d;
  logic [1:0]  nb_s;

  // Next-state and next-output computation for the framing FSM.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    gap_d        = gap_q;
    half_d       = half_q;
    bytes_left_d = bytes_left_q;
    frame_d      = frame_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    miso_byte_d  = miso_byte_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    ss_d         = ss_q;

    // A count of 3 is clamped to 2 data bytes.
    case (i_nbytes)
      2'd0:    nb_s = 2'd0;
      2'd1:    nb_s = 2'd1;
      default: nb_s = 2'd2;
    endcase

    case (state_q)
      IDLE: begin
        if (i_start) begin
          bytes_left_d = {1'b0, nb_s} + {2'b00, i_kick};
          case (nb_s)
            2'd0:    frame_d = 24'h00_0000;
            2'd1:    frame_d = {i_data[7:0], 16'h0000};
            default: frame_d = {i_data[15:8], i_data[7:0], 8'h00};
          endcase
          tx_d    = {i_addr[6:0], 1'b0};
          mosi_d  = i_addr[7];
          rx_d    = 8'h00;
          div_d   = '0;
          half_d  = 4'd0;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          half_d = half_q + 4'd1;
          if (half_q == 4'd15) begin
            sclk_d      = 1'b0;
            mosi_d      = 1'b0;
            ss_d        = 1'b1;
            miso_byte_d = rx_q;
            gap_d       = '0;
            state_d     = GAP;
          end else if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], i_spi_miso};
          end else begin
            sclk_d = 1'b0;
            mosi_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (bytes_left_q != 3'd0) begin
            bytes_left_d = bytes_left_q - 3'd1;
            mosi_d       = frame_q[23];
            tx_d         = {frame_q[22:16], 1'b0};
            frame_d      = {frame_q[15:0], 8'h00};
            rx_d         = 8'h00;
            div_d        = '0;
            half_d       = 4'd0;
            ss_d         = 1'b0;
            state_d      = SHIFT;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk50mhz) begin
    if (i_rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      gap_q        <= '0;
      half_q       <= 4'd0;
      bytes_left_q <= 3'd0;
      frame_q      <= 24'h00_0000;
      tx_q         <= 8'h00;
      rx_q         <= 8'h00;
      miso_byte_q  <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      ss_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      gap_q        <= gap_d;
      half_q       <= half_d;
      bytes_left_q <= bytes_left_d;
      frame_q      <= frame_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      miso_byte_q  <= miso_byte_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      ss_q         <= ss_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_spi_clk   = sclk_q;
  assign o_spi_mosi  = mosi_q;
  assign o_spi_ss    = ss_q;
  assign o_miso_byte = miso_byte_q;

endmodule
